pic_priority_core: RTL and testbench
====================================

# pic_priority_core

Parametrised, clocked interrupt priority core for the PIC family, generalising the fixed 8-input 8259A-style controller to `NUM_IRQ` channels. It latches requests (edge or level), applies a mask, resolves priority (fixed or rotating, fully nested), raises `int_out`, and returns a vector on a single-cycle acknowledge. It also tracks in-service state until EOI. It sits between the synchronised IR lines and the bus/cascade front end, which handles CPU read/write decoding.

## Interface
- `NUM_IRQ`, 8: number of request channels (2..32).
- `IDX_W`, `$clog2(NUM_IRQ)`: channel index width.
- `VEC_W`, 8: vector width, ≥ `IDX_W`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `irq_in`  in  NUM_IRQ  request lines, synchronous to `clk`; synchronisers live outside this block.
- `cfg_level`  in  1  1 = level-triggered, 0 = rising-edge-triggered.
- `cfg_rotate`  in  1  1 = automatic rotation on EOI.
- `cfg_auto_eoi`  in  1  1 = ISR bit not set on acknowledge.
- `imr_wr`  in  1  load `imr_data` into IMR.
- `imr_data`  in  NUM_IRQ  mask value, 1 = masked.
- `vec_base`  in  VEC_W  vector base; the low `IDX_W` bits are ignored.
- `inta_req`  in  1  one-cycle acknowledge pulse.
- `eoi`  in  1  one-cycle non-specific EOI pulse.
- `int_out`  out  1  interrupt request to CPU.
- `vec_valid`  out  1  one-cycle strobe; `vec_out` is valid.
- `vec_out`  out  VEC_W  `{vec_base[VEC_W-1:IDX_W], idx}`.
- `irr_o`, `isr_o`, `imr_o`  out  NUM_IRQ  register state, for readback.

## Operation
- Registers: IRR, ISR, IMR, `irq_prev`, priority pointer `ptr` (index of the highest-priority channel), `vec_out`, `vec_valid`.
- Reset values:
  - IRR = ISR = IMR = 0.
  - `irq_prev` = 0; `ptr` = 0.
  - `vec_out` = 0; `vec_valid` = 0.
  - `int_out` = 0.
- Request capture:
  - Edge mode: IRR |= `irq_in & ~irq_prev`.
  - Level mode: IRR = `irq_in`.
  - In both modes the bit acknowledged this cycle is cleared, and the clear wins over a same-cycle set on that bit.
  - Masked channels still latch into IRR.
- Priority order: `ptr`, `ptr+1`, … wrapping mod `NUM_IRQ`; `ptr` is highest.
- Candidate: the highest-priority bit of `IRR & ~IMR`.
- `isr_top`: the highest-priority bit of ISR.
- `int_out` = candidate exists AND (ISR == 0 OR the candidate outranks `isr_top`). Fully nested: equal or lower priority never interrupts.
- Acknowledge (`inta_req`=1):
  - If `int_out`=1:
    - Clear IRR[cand].
    - Set ISR[cand] unless `cfg_auto_eoi`.
    - `vec_out` = base | cand.
    - If `cfg_auto_eoi` && `cfg_rotate`, set `ptr` = (cand+1) mod `NUM_IRQ`.
  - If `int_out`=0 (spurious): `vec_out` = base | (`NUM_IRQ`-1); IRR, ISR and `ptr` unchanged.
  - `vec_valid` pulses in either case.
- EOI (`eoi`=1):
  - Clears ISR[`isr_top`] of the pre-edge ISR.
  - If `cfg_rotate`, set `ptr` = (`isr_top`+1) mod `NUM_IRQ`.
  - EOI with ISR == 0 is a no-op.
- Simultaneous `inta_req` and `eoi`:
  - Both are evaluated on pre-edge state and both are applied.
  - The EOI clears the old `isr_top`; the acknowledge sets the new bit.
  - If both rotate, the acknowledge's `ptr` update wins.
- IMR write takes effect at the edge. It also affects `int_out` in the following cycle, including deasserting it if the only candidate becomes masked.
- Config inputs are quasi-static. Changing `cfg_level` drops only edge history; IRR is not cleared.

## Timing
- `irq_in` rises, sampled at edge k: IRR set at k; `int_out` is combinational from registers and is high after k.
- `inta_req` sampled at edge k: `vec_out`/`vec_valid` registered at k, so latency 1. `vec_valid` is high for exactly one cycle. `int_out` is re-evaluated after k.
- Back-to-back `inta_req` on consecutive cycles is legal; each pulse is handled independently.
- Async `rst_n` low mid-operation: all registers go to reset values immediately, and `int_out` drops without waiting for a clock edge.

## Test plan
- Reset, edge mode, NUM_IRQ=8, base 0x40: pulse `irq_in[3]` → IRR=0x08, `int_out`=1. Then `inta_req` → `vec_out`=0x43, `vec_valid` one cycle, ISR=0x08, `int_out`=0.
- ISR=0x08 (IR3 in service): raise IR5 → `int_out` stays 0. Raise IR1 → `int_out`=1; acknowledge → vector 0x41, ISR=0x0A. `eoi` → ISR=0x08.
- IMR=0x01 and `irq_in[0]` pulsed → IRR=0x01, `int_out`=0. Then write IMR=0 → `int_out`=1 next cycle.
- Spurious: `inta_req` with `int_out`=0 and base 0x40 → `vec_out`=0x47; ISR and IRR unchanged.
- Rotation, `cfg_rotate`=1: IR2 and IR6 both pending → acknowledge → vector base|2. `eoi` → `ptr`=3. Acknowledge again → vector base|6.
- NUM_IRQ=16, level mode, base 0x80: hold IR15 high → acknowledge → `vec_out`=0x8F. Assert `rst_n`=0 mid-service → IRR, ISR and `int_out` all clear asynchronously.

Source files
------------

// File: rtl/pic_priority_core.sv
// Interrupt priority core: IRR/ISR/IMR, fixed or rotating fully nested priority, vector on acknowledge.
// int_out is combinational from registers; vec_out/vec_valid register 1 cycle after inta_req; no backpressure.
module pic_priority_core #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_level,
  input  logic               cfg_rotate,
  input  logic               cfg_auto_eoi,
  input  logic               imr_wr,
  input  logic [NUM_IRQ-1:0] imr_data,
  input  logic [VEC_W-1:0]   vec_base,
  input  logic               inta_req,
  input  logic               eoi,
  output logic               int_out,
  output logic               vec_valid,
  output logic [VEC_W-1:0]   vec_out,
  output logic [NUM_IRQ-1:0] irr_o,
  output logic [NUM_IRQ-1:0] isr_o,
  output logic [NUM_IRQ-1:0] imr_o
);

  localparam logic [VEC_W-1:0] BASE_MASK = ~VEC_W'((1 << IDX_W) - 1);
  localparam logic [IDX_W-1:0] SPUR_IDX  = IDX_W'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [VEC_W-1:0]   vec_out_q, vec_out_d;
  logic               vec_valid_q, vec_valid_d;

  logic [NUM_IRQ-1:0] masked_req;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   isr_top;
  logic               cand_vld;
  logic               isr_vld;
  logic               int_raw;
  logic               ack_vld;
  logic               eoi_vld;

  // Walk from lowest to highest priority so the last hit is the winner.
  function automatic logic [IDX_W-1:0] top_idx(input logic [NUM_IRQ-1:0] v,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] best;
    int               idx;
    best = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (v[IDX_W'(idx)]) best = IDX_W'(idx);
    end
    return best;
  endfunction

  // Distance from the pointer: 0 is the highest priority.
  function automatic int rank(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] p);
    int r;
    r = int'(i) - int'(p);
    if (r < 0) r = r + NUM_IRQ;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_IRQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    masked_req = irr_q & ~imr_q;
    cand_vld   = |masked_req;
    cand_idx   = top_idx(masked_req, ptr_q);
    isr_vld    = |isr_q;
    isr_top    = top_idx(isr_q, ptr_q);
    int_raw    = cand_vld && (!isr_vld || (rank(cand_idx, ptr_q) < rank(isr_top, ptr_q)));
    ack_vld    = inta_req && int_raw;
    eoi_vld    = eoi && isr_vld;
  end

  always_comb begin
    ack_mask = '0;
    if (ack_vld) ack_mask[cand_idx] = 1'b1;
    edge_set   = irq_in & ~irq_prev_q;
    // Level mode keeps no edge history, so a return to edge mode starts clean.
    irq_prev_d = cfg_level ? '0 : irq_in;
    irr_d      = (cfg_level ? irq_in : (irr_q | edge_set)) & ~ack_mask;
    imr_d      = imr_wr ? imr_data : imr_q;
  end

  // EOI clears the old top before the acknowledge sets the new bit.
  always_comb begin
    isr_d = isr_q;
    ptr_d = ptr_q;
    if (eoi_vld) begin
      isr_d[isr_top] = 1'b0;
      if (cfg_rotate) ptr_d = next_idx(isr_top);
    end
    if (ack_vld) begin
      if (!cfg_auto_eoi) isr_d[cand_idx] = 1'b1;
      else if (cfg_rotate) ptr_d = next_idx(cand_idx);
    end
  end

  always_comb begin
    vec_out_d   = vec_out_q;
    vec_valid_d = inta_req;
    if (inta_req) begin
      vec_out_d = (vec_base & BASE_MASK) | VEC_W'(ack_vld ? cand_idx : SPUR_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      irq_prev_q  <= '0;
      ptr_q       <= '0;
      vec_out_q   <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      irq_prev_q  <= irq_prev_d;
      ptr_q       <= ptr_d;
      vec_out_q   <= vec_out_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign int_out   = int_raw;
  assign vec_valid = vec_valid_q;
  assign vec_out   = vec_out_q;
  assign irr_o     = irr_q;
  assign isr_o     = isr_q;
  assign imr_o     = imr_q;

endmodule

// File: tb/tb_pic_priority_core.sv
// Bench for pic_priority_core: 8-channel edge-mode instance and 16-channel level-mode instance.
module tb_pic_priority_core;

  logic clk;
  logic rst_n;

  logic [7:0]  a_irq, a_imr_data, a_base, a_vec, a_irr, a_isr, a_imr;
  logic        a_level, a_rotate, a_auto, a_imr_wr, a_inta, a_eoi, a_int, a_vv;
  logic [15:0] b_irq, b_imr_data, b_irr, b_isr, b_imr;
  logic [7:0]  b_base, b_vec;
  logic        b_level, b_rotate, b_auto, b_imr_wr, b_inta, b_eoi, b_int, b_vv;

  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  int n_chk;
  int n_err;

  pic_priority_core #(.NUM_IRQ(8), .VEC_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .irq_in(a_irq), .cfg_level(a_level),
    .cfg_rotate(a_rotate), .cfg_auto_eoi(a_auto), .imr_wr(a_imr_wr),
    .imr_data(a_imr_data), .vec_base(a_base), .inta_req(a_inta), .eoi(a_eoi),
    .int_out(a_int), .vec_valid(a_vv), .vec_out(a_vec),
    .irr_o(a_irr), .isr_o(a_isr), .imr_o(a_imr)
  );

  pic_priority_core #(.NUM_IRQ(16), .VEC_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .irq_in(b_irq), .cfg_level(b_level),
    .cfg_rotate(b_rotate), .cfg_auto_eoi(b_auto), .imr_wr(b_imr_wr),
    .imr_data(b_imr_data), .vec_base(b_base), .inta_req(b_inta), .eoi(b_eoi),
    .int_out(b_int), .vec_valid(b_vv), .vec_out(b_vec),
    .irr_o(b_irr), .isr_o(b_isr), .imr_o(b_imr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboards: each vec_valid strobe consumes one expected vector.
  initial begin
    forever begin
      @(negedge clk);
      if (a_vv) begin
        if (a_q.size() == 0) check("a_vec_extra", {31'd0, a_vv}, 32'd0);
        else check("a_vec", {24'd0, a_vec}, {24'd0, a_q.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (b_vv) begin
        if (b_q.size() == 0) check("b_vec_extra", {31'd0, b_vv}, 32'd0);
        else check("b_vec", {24'd0, b_vec}, {24'd0, b_q.pop_front()});
      end
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_irq = '0; a_imr_data = '0; a_base = 8'h40; a_level = 1'b0; a_rotate = 1'b0;
    a_auto = 1'b0; a_imr_wr = 1'b0; a_inta = 1'b0; a_eoi = 1'b0;
    b_irq = '0; b_imr_data = '0; b_base = 8'h80; b_level = 1'b1; b_rotate = 1'b0;
    b_auto = 1'b0; b_imr_wr = 1'b0; b_inta = 1'b0; b_eoi = 1'b0;
    repeat (2) step();
    check("rst_irr", a_irr, 0);
    check("rst_isr", a_isr, 0);
    check("rst_imr", a_imr, 0);
    check("rst_int", a_int, 0);
    check("rst_vv", a_vv, 0);
    check("rst_vec", a_vec, 0);
    rst_n = 1'b1;
    step();

    // Basic edge capture and acknowledge
    a_irq = 8'h08; step(); a_irq = '0;
    check("t1_irr", a_irr, 8'h08);
    check("t1_int", a_int, 1);
    a_inta = 1'b1; a_q.push_back(8'h43); step(); a_inta = 1'b0;
    check("t1_isr", a_isr, 8'h08);
    check("t1_irr_clr", a_irr, 8'h00);
    check("t1_int_lo", a_int, 0);
    step();
    check("t1_vv_one", a_vv, 0);

    // Nesting: lower priority blocked, higher priority interrupts
    a_irq = 8'h20; step(); a_irq = '0;
    check("t2_irr5", a_irr, 8'h20);
    check("t2_int_blk", a_int, 0);
    a_irq = 8'h02; step(); a_irq = '0;
    check("t2_irr15", a_irr, 8'h22);
    check("t2_int_nest", a_int, 1);
    a_inta = 1'b1; a_q.push_back(8'h41); step(); a_inta = 1'b0;
    check("t2_isr", a_isr, 8'h0A);
    check("t2_int_after", a_int, 0);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;
    check("t2_eoi1", a_isr, 8'h08);
    check("t2_int_ir5", a_int, 0);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;
    check("t2_eoi2", a_isr, 8'h00);
    check("t2_int_free", a_int, 1);
    a_inta = 1'b1; a_q.push_back(8'h45); step(); a_inta = 1'b0;
    check("t2_isr5", a_isr, 8'h20);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;
    check("t2_isr_clr", a_isr, 8'h00);

    // Mask latches but suppresses, unmask raises int_out
    a_imr_wr = 1'b1; a_imr_data = 8'h01; a_irq = 8'h01; step();
    a_imr_wr = 1'b0; a_irq = '0;
    check("t3_imr", a_imr, 8'h01);
    check("t3_irr", a_irr, 8'h01);
    check("t3_int_mask", a_int, 0);
    a_imr_wr = 1'b1; a_imr_data = 8'h00; step(); a_imr_wr = 1'b0;
    check("t3_int_unmask", a_int, 1);
    a_inta = 1'b1; a_q.push_back(8'h40); step(); a_inta = 1'b0;
    check("t3_isr", a_isr, 8'h01);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;

    // Spurious acknowledge leaves state untouched
    a_imr_wr = 1'b1; a_imr_data = 8'h10; a_irq = 8'h10; step();
    a_imr_wr = 1'b0; a_irq = '0;
    check("t4_int", a_int, 0);
    a_inta = 1'b1; a_q.push_back(8'h47); step(); a_inta = 1'b0;
    check("t4_irr", a_irr, 8'h10);
    check("t4_isr", a_isr, 8'h00);
    a_imr_wr = 1'b1; a_imr_data = 8'h00; step(); a_imr_wr = 1'b0;
    a_inta = 1'b1; a_q.push_back(8'h44); step(); a_inta = 1'b0;
    a_eoi = 1'b1; step(); a_eoi = 1'b0;
    check("t4_clean", a_isr | a_irr, 8'h00);

    // Rotation on EOI: ptr moves to 3 so IR6 beats IR0
    a_rotate = 1'b1;
    a_irq = 8'h44; step(); a_irq = '0;
    check("t5_irr", a_irr, 8'h44);
    a_inta = 1'b1; a_q.push_back(8'h42); step(); a_inta = 1'b0;
    check("t5_isr2", a_isr, 8'h04);
    check("t5_int_blk", a_int, 0);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;
    a_irq = 8'h01; step(); a_irq = '0;
    check("t5_irr2", a_irr, 8'h41);
    a_inta = 1'b1; a_q.push_back(8'h46); step(); a_inta = 1'b0;
    check("t5_isr6", a_isr, 8'h40);
    check("t5_int_ir0", a_int, 0);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;
    check("t5_int_ir0b", a_int, 1);

    // Back-to-back acknowledges: real, then spurious
    a_inta = 1'b1; a_q.push_back(8'h40); step();
    a_q.push_back(8'h47); step(); a_inta = 1'b0;
    check("t6_isr", a_isr, 8'h01);
    check("t6_irr", a_irr, 8'h00);
    a_eoi = 1'b1; step(); a_eoi = 1'b0;

    // Auto-EOI with rotation: ptr follows each acknowledged channel
    a_auto = 1'b1;
    a_irq = 8'h08; step(); a_irq = '0;
    a_inta = 1'b1; a_q.push_back(8'h43); step(); a_inta = 1'b0;
    check("t7_isr_auto", a_isr, 8'h00);
    a_irq = 8'h18; step(); a_irq = '0;
    a_inta = 1'b1; a_q.push_back(8'h44); step(); a_inta = 1'b0;
    check("t7_irr", a_irr, 8'h08);
    a_inta = 1'b1; a_q.push_back(8'h43); step(); a_inta = 1'b0;
    check("t7_irr_clr", a_irr, 8'h00);
    a_auto = 1'b0; a_rotate = 1'b0;

    // Simultaneous acknowledge and EOI (ptr = 4: IR5 outranks IR7)
    a_irq = 8'h80; step(); a_irq = '0;
    a_inta = 1'b1; a_q.push_back(8'h47); step(); a_inta = 1'b0;
    check("t8_isr7", a_isr, 8'h80);
    a_irq = 8'h20; step(); a_irq = '0;
    check("t8_int", a_int, 1);
    a_inta = 1'b1; a_eoi = 1'b1; a_q.push_back(8'h45); step();
    a_inta = 1'b0; a_eoi = 1'b0;
    check("t8_isr", a_isr, 8'h20);

    // 16 channels, level mode, async reset mid-service
    b_irq = 16'h8000; step();
    check("b_irr", b_irr, 16'h8000);
    check("b_int", b_int, 1);
    b_inta = 1'b1; b_q.push_back(8'h8F); step(); b_inta = 1'b0;
    check("b_isr", b_isr, 16'h8000);
    check("b_irr_ackclr", b_irr, 16'h0000);
    check("b_int_lo", b_int, 0);
    step();
    check("b_irr_relevel", b_irr, 16'h8000);
    check("b_int_same", b_int, 0);
    #2 rst_n = 1'b0;
    #1;
    check("b_arst_irr", b_irr, 16'h0000);
    check("b_arst_isr", b_isr, 16'h0000);
    check("b_arst_int", b_int, 0);
    check("a_arst_isr", a_isr, 8'h00);
    step(); rst_n = 1'b1; step();
    check("b_post_irr", b_irr, 16'h8000);
    check("b_post_int", b_int, 1);
    b_irq = '0;
    repeat (3) step();

    check("a_q_left", a_q.size(), 0);
    check("b_q_left", b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
